// File: rtl/vector_fetch_engine.sv
// Single-outstanding vector fetcher: pops an address, issues a one-beat read and pushes the data.
// Optional read timeout is built when FETCH_TIMEOUT_EN is defined.
module vector_fetch_engine #(
  parameter int VCTR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_program,
  input  logic [31:0]       addr_fifo_dout,
  input  logic              addr_fifo_empty,
  output logic              addr_fifo_rd,
  output logic [31:0]       master_addr,
  output logic              master_rd,
  input  logic [VCTR_W-1:0] master_data_in,
  input  logic              master_data_in_val,
  output logic [VCTR_W-1:0] vctr_fifo_din,
  output logic              vctr_fifo_wr,
  input  logic              vctr_fifo_full,
  input  logic [15:0]       words_in_vctr_fifo,
  input  logic [15:0]       vector_fifo_threshold,
  output logic              fetch_busy,
  output logic [15:0]       fetch_cnt,
  output logic              rd_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_PUSH  = 3'd4
  } state_t;

  state_t            state_q;
  logic [31:0]       master_addr_q;
  logic              master_rd_q;
  logic [VCTR_W-1:0] vctr_din_q;
  logic [15:0]       fetch_cnt_q;
  logic              run_q;
  logic              run_rise;
  logic              start;
  logic              push_ok;

  // All strobes are single-cycle: the addr FIFO pops on the edge closing an addr_fifo_rd cycle and
  // presents data the cycle after; a vctr_fifo_wr cycle transfers vctr_fifo_din on its closing edge.
  assign start = (state_q == S_IDLE) && run_program && !addr_fifo_empty && !vctr_fifo_full &&
                 (words_in_vctr_fifo < vector_fifo_threshold) && !reset;
  assign push_ok  = (state_q == S_PUSH) && !vctr_fifo_full && !reset;
  assign run_rise = run_program && !run_q;

  assign addr_fifo_rd  = start;
  assign vctr_fifo_wr  = push_ok;
  assign master_addr   = master_addr_q;
  assign master_rd     = master_rd_q;
  assign vctr_fifo_din = vctr_din_q;
  assign fetch_busy    = (state_q != S_IDLE);
  assign fetch_cnt     = fetch_cnt_q;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;
  assign rd_timeout_err = err_q;
`else
  assign rd_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      master_addr_q <= '0;
      master_rd_q   <= 1'b0;
      vctr_din_q    <= '0;
      fetch_cnt_q   <= '0;
      run_q         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      run_q       <= run_program;
      master_rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_LATCH;
        end
        S_LATCH: begin
          // FIFO data is valid now, one cycle after the pop; master_rd pulses next cycle.
          master_addr_q <= addr_fifo_dout;
          master_rd_q   <= 1'b1;
          state_q       <= S_ISSUE;
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (master_data_in_val) begin
            vctr_din_q <= master_data_in;
            state_q    <= S_PUSH;
`ifdef FETCH_TIMEOUT_EN
          end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
`endif
          end
        end
        S_PUSH: begin
          if (push_ok) begin
            state_q <= S_IDLE;
            if (fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A new run starts from clean statistics, even over a push in the same cycle.
      if (run_rise) begin
        fetch_cnt_q <= '0;
`ifdef FETCH_TIMEOUT_EN
        err_q       <= 1'b0;
`endif
      end
    end
  end

endmodule
